seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//   Time-multiplexed N-digit 7-segment display driver. Accepts a packed hex
//   value, double-buffers it, and scans digits one at a time with a guard
//   (ghost-blanking) interval. Sits between core logic and board anode and
//   segment pins; successor to the single-digit combinational decoder.
// PARAMETERS
//   DIGITS        4       number of digits scanned (1..8)
//   SCAN_DIV      100000  clk cycles per digit slot (>= GUARD+2)
//   GUARD         16      cycles at slot start with all anodes off
//   SEG_ACT_LOW   0       1: seg_o active-low; 0: active-high (bit6=g..bit0=a)
//   AN_ACT_LOW    1       1: an_o active-low
// PORTS
//   clk       in   1          system clock
//   rst_n     in   1          synchronous reset, active-low
//   en        in   1          scan enable; 0 freezes scan, display dark
//   load      in   1          strobe: capture value_i/blank_i into pending buffer
//   value_i   in   4*DIGITS   hex nibbles; nibble 0 = rightmost digit
//   blank_i   in   DIGITS     per-digit force-blank mask
//   frame_o   out  1          1-cycle pulse at each frame start (idx wraps to 0)
//   an_o      out  DIGITS     digit select, one-hot active (polarity AN_ACT_LOW)
//   seg_o     out  7          segments gfedcba (polarity SEG_ACT_LOW)
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): cnt=0, idx=0, pending=0, pend_vld=0,
//     disp=0, disp_blank=all-1s, frame_o=0, an_o all inactive, seg_o all off.
//   - Prescaler cnt counts 0..SCAN_DIV-1 while en=1; at SCAN_DIV-1 wraps to 0
//     and idx advances; idx DIGITS-1 -> 0 is the frame boundary.
//   - Buffering: load=1 writes pending<=value_i/blank_i, pend_vld<=1; last
//     load before a boundary wins. At boundary: if pend_vld, disp<=pending,
//     pend_vld<=0. load on the boundary cycle bypasses: that cycle's value_i
//     goes straight to disp. No mid-frame tearing ever.
//   - frame_o asserts the cycle after the boundary edge (registered, 1 cycle).
//   - Outputs registered, 1-cycle latency from (idx,cnt): an_o active for
//     digit idx only when cnt>=GUARD; during cnt<GUARD all anodes inactive.
//   - seg_o = hex2seg(disp nibble[idx]), forced off when digit blanked or
//     guard active. Codes: 0..9 = 3F 06 5B 4F 66 6D 7D 07 7F 6F;
//     A..F = 77 7C 39 5E 79 71 (active-high hex), all 16 codes defined.
//   - en=0: cnt/idx hold, an_o inactive, seg_o off, load still accepted;
//     on en 1 scan resumes from held cnt/idx.
//   - Reset mid-slot or mid-frame: immediate return to reset state next edge;
//     pending load lost.
//   - DIGITS=1: every slot wrap is a frame boundary.
// CONFIGURATION
//   SEG_LZB_EN defined: leading-zero blanking; digits above the highest
//     nonzero nibble of disp are blanked (OR'd with disp_blank); digit 0 is
//     never blanked by LZB (value 0 shows "0").
//   SEG_LZB_EN undefined: all digits shown unless blank_i mask set.
// STRUCTURE
//   Package seg_pkg: typedef logic [6:0] seg_t; SEG_OFF constant;
//     function hex2seg(logic [3:0]) -> seg_t (active-high table above).
//   Sub-module seg_hex_decode: combinational nibble -> seg_t wrapper of
//     hex2seg; polarity inversion done in seg_scan_driver output stage.
// TESTING (DIGITS=4, SCAN_DIV=8, GUARD=2, SEG_ACT_LOW=0, AN_ACT_LOW=1)
//   1 Reset: hold rst_n=0 3 cycles -> an_o=4'hF, seg_o=7'h00, frame_o=0.
//   2 load value_i=16'h12AF, wait boundary -> slots show seg 71,77,5B,06 on
//     an_o E,D,B,7; each slot 2 cycles an_o=F then 6 cycles active.
//   3 load 16'h1111 mid-frame -> current frame unchanged; new value from
//     first slot after frame_o pulse; loads 16'h2222 then 16'h3333 in one
//     frame -> only 3333 displayed.
//   4 load on boundary cycle with 16'h0BEE -> that frame shows 79,79,7C,3F.
//   5 en=0 for 20 cycles mid-slot -> an_o=F, seg_o=00, cnt/idx frozen;
//     en=1 -> slot completes its remaining cycles.
//   6 SEG_LZB_EN, value 16'h0042 -> digits 3,2 dark, shows 42; value 0 ->
//     only digit 0 lit with 3F; blank_i=4'b0001 blanks digit 0 regardless.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scan driver.
// Segment vectors are ordered gfedcba (bit6 = g, bit0 = a) and are always
// active-high here; any pin polarity inversion happens in the driver output stage.
package seg_pkg;

   typedef logic [6:0] seg_t;

   // All segments dark in active-high form.
   localparam seg_t SEG_OFF = 7'h00;

   // Maps one hex nibble to its active-high segment pattern. All 16 codes are defined.
   function automatic seg_t hex2seg(input logic [3:0] nib);
      seg_t seg;
      case (nib)
         4'h0:    seg = 7'h3F;
         4'h1:    seg = 7'h06;
         4'h2:    seg = 7'h5B;
         4'h3:    seg = 7'h4F;
         4'h4:    seg = 7'h66;
         4'h5:    seg = 7'h6D;
         4'h6:    seg = 7'h7D;
         4'h7:    seg = 7'h07;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h6F;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h7C;
         4'hC:    seg = 7'h39;
         4'hD:    seg = 7'h5E;
         4'hE:    seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-segment decoder. It produces the active-high
// gfedcba pattern; the caller applies any pin polarity.
module seg_hex_decode
   import seg_pkg::*;
(
   input  logic [3:0] nib_i,
   output seg_t       seg_o
);

   assign seg_o = hex2seg(nib_i);

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment display driver.
// It double-buffers a packed hex value so the display never tears mid-frame.
// It scans one digit per slot and keeps all anodes off for GUARD cycles at the
// start of each slot to prevent ghosting.
// Optional build macro: SEG_LZB_EN enables leading-zero blanking. Digit 0 is
// never blanked by this feature.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int SCAN_DIV    = 100000,
   parameter int GUARD       = 16,
   parameter bit SEG_ACT_LOW = 1'b0,
   parameter bit AN_ACT_LOW  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value_i,
   input  logic [DIGITS-1:0]     blank_i,
   output logic                  frame_o,
   output logic [DIGITS-1:0]     an_o,
   output logic [6:0]            seg_o
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Inactive pin levels. XOR-ing an active-high vector with these applies the pin polarity.
   localparam logic [DIGITS-1:0] AN_IDLE  = AN_ACT_LOW  ? '1 : '0;
   localparam seg_t              SEG_IDLE = SEG_ACT_LOW ? ~SEG_OFF : SEG_OFF;

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*DIGITS-1:0]   pend_q, pend_d;
   logic [DIGITS-1:0]     pend_blank_q, pend_blank_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [4*DIGITS-1:0]   disp_q, disp_d;
   logic [DIGITS-1:0]     disp_blank_q, disp_blank_d;
   logic                  frame_q, frame_d;
   logic [DIGITS-1:0]     an_q, an_d;
   seg_t                  seg_q, seg_d;

   logic                  slot_end;
   logic                  frame_end;
   logic                  lit;
   logic                  digit_blank;
   logic [3:0]            cur_nib;
   seg_t                  dec_seg;
   logic [DIGITS-1:0]     lzb_mask;

   assign slot_end  = en && (cnt_q == CNT_W'(SCAN_DIV - 1));
   assign frame_end = slot_end && (idx_q == IDX_W'(DIGITS - 1));
   assign lit       = en && (cnt_q >= CNT_W'(GUARD));
   assign cur_nib   = disp_q[{idx_q, 2'b00} +: 4];

   seg_hex_decode u_dec (
      .nib_i (cur_nib),
      .seg_o (dec_seg)
   );

`ifdef SEG_LZB_EN
   logic lzb_zero_above;

   // A digit is blanked when it and every digit to its left hold zero. Digit 0 is always kept.
   always_comb begin
      lzb_mask       = '0;
      lzb_zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         lzb_zero_above = lzb_zero_above & (disp_q[4*i +: 4] == 4'h0);
         lzb_mask[i]    = lzb_zero_above;
      end
   end
`else
   assign lzb_mask = '0;
`endif

   assign digit_blank = disp_blank_q[idx_q] | lzb_mask[idx_q];

   // Next-state logic: prescaler/index, double buffer, frame pulse and pin drive.
   always_comb begin
      // NOTE: every *_d is defaulted to its held value first so no branch can infer a latch.
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      pend_d       = pend_q;
      pend_blank_d = pend_blank_q;
      pend_vld_d   = pend_vld_q;
      disp_d       = disp_q;
      disp_blank_d = disp_blank_q;
      frame_d      = frame_end;
      an_d         = AN_IDLE;
      seg_d        = SEG_IDLE;

      if (en) begin
         if (slot_end) begin
            cnt_d = '0;
            idx_d = frame_end ? '0 : idx_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (load) begin
         pend_d       = value_i;
         pend_blank_d = blank_i;
         pend_vld_d   = 1'b1;
      end

      // The display buffer only changes on a frame boundary. A load on that same cycle bypasses the pending buffer.
      if (frame_end) begin
         pend_vld_d = 1'b0;
         if (load) begin
            disp_d       = value_i;
            disp_blank_d = blank_i;
         end else if (pend_vld_q) begin
            disp_d       = pend_q;
            disp_blank_d = pend_blank_q;
         end
      end

      if (lit) begin
         an_d = AN_IDLE ^ (DIGITS'(1) << idx_q);
         if (!digit_blank) begin
            seg_d = dec_seg ^ SEG_IDLE;
         end
      end
   end

   // State register with synchronous active-low reset. A reset discards any pending load.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_q       <= '0;
         pend_blank_q <= '0;
         pend_vld_q   <= 1'b0;
         disp_q       <= '0;
         disp_blank_q <= '1;
         frame_q      <= 1'b0;
         an_q         <= AN_IDLE;
         seg_q        <= SEG_IDLE;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         pend_blank_q <= pend_blank_d;
         pend_vld_q   <= pend_vld_d;
         disp_q       <= disp_d;
         disp_blank_q <= disp_blank_d;
         frame_q      <= frame_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
      end
   end

   assign frame_o = frame_q;
   assign an_o    = an_q;
   assign seg_o   = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (4 digits, 8-cycle slots, 2-cycle guard).
// A frame-position reference model predicts an_o/seg_o/frame_o every cycle.
// Directed frames are also checked against fixed segment codes.
module tb_seg_scan_driver;

   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 8;
   localparam int GUARD    = 2;
   localparam int FRAME    = DIGITS * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value_i = '0;
   logic [3:0]  blank_i = '0;
   logic        frame_o;
   logic [3:0]  an_o;
   logic [6:0]  seg_o;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: position within the frame plus the two buffers.
   int          m_pos;
   logic [15:0] m_disp, m_pend;
   logic [3:0]  m_dblank, m_pblank;
   logic        m_pvld;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_frame;

   logic [6:0] seg_rom [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

`ifdef SEG_LZB_EN
   localparam logic [6:0] D3_0BEE = 7'h00;
`else
   localparam logic [6:0] D3_0BEE = 7'h3F;
`endif

   seg_scan_driver #(
      .DIGITS      (DIGITS),
      .SCAN_DIV    (SCAN_DIV),
      .GUARD       (GUARD),
      .SEG_ACT_LOW (1'b0),
      .AN_ACT_LOW  (1'b1)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .load    (load),
      .value_i (value_i),
      .blank_i (blank_i),
      .frame_o (frame_o),
      .an_o    (an_o),
      .seg_o   (seg_o)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advances the model by one clock edge. Outputs are predicted from the pre-edge state.
   task automatic model_edge();
      int       idx, c, hi;
      logic     blanked;
      logic [3:0] nib;
      if (!rst_n) begin
         m_pos = 0; m_disp = '0; m_pend = '0; m_dblank = 4'hF; m_pblank = '0; m_pvld = 1'b0;
         exp_an = 4'hF; exp_seg = 7'h00; exp_frame = 1'b0;
         return;
      end
      idx     = m_pos / SCAN_DIV;
      c       = m_pos % SCAN_DIV;
      nib     = m_disp[4*idx +: 4];
      blanked = m_dblank[idx];
`ifdef SEG_LZB_EN
      hi = 0;
      for (int i = 0; i < DIGITS; i++) if (m_disp[4*i +: 4] != 4'h0) hi = i;
      if (idx > hi) blanked = 1'b1;
`else
      hi = 0;
`endif
      if (en && c >= GUARD) begin
         exp_an  = ~(4'b0001 << idx);
         exp_seg = blanked ? 7'h00 : seg_rom[nib];
      end else begin
         exp_an  = 4'hF;
         exp_seg = 7'h00;
      end
      exp_frame = en && (m_pos == FRAME - 1);
      if (load) begin
         m_pend = value_i; m_pblank = blank_i; m_pvld = 1'b1;
      end
      if (exp_frame) begin
         if (load) begin
            m_disp = value_i; m_dblank = blank_i;
         end else if (m_pvld) begin
            m_disp = m_pend; m_dblank = m_pblank;
         end
         m_pvld = 1'b0;
      end
      if (en) m_pos = (m_pos + 1) % FRAME;
   endtask

   task automatic step(input logic r, input logic e, input logic l,
                       input logic [15:0] v, input logic [3:0] b);
      @(negedge clk);
      rst_n = r; en = e; load = l; value_i = v; blank_i = b;
      @(posedge clk);
      model_edge();
      #1;
      check("an_o", {28'd0, an_o}, {28'd0, exp_an});
      check("seg_o", {25'd0, seg_o}, {25'd0, exp_seg});
      check("frame_o", {31'd0, frame_o}, {31'd0, exp_frame});
   endtask

   task automatic idle();
      step(1'b1, 1'b1, 1'b0, 16'h0000, 4'h0);
   endtask

   task automatic wait_frame();
      bit seen = 1'b0;
      for (int n = 0; n < 4 * FRAME && !seen; n++) begin
         idle();
         if (frame_o === 1'b1) seen = 1'b1;
      end
      check("wait_frame", {31'd0, seen}, 32'd1);
   endtask

   task automatic seek(input int target, input int modulus);
      bit hit = (m_pos % modulus) == target;
      for (int n = 0; n < 2 * FRAME && !hit; n++) begin
         idle();
         hit = (m_pos % modulus) == target;
      end
      check("seek", {31'd0, hit}, 32'd1);
   endtask

   // Checks one whole frame after a frame pulse. segs packs {digit3..digit0}, 7 bits each.
   task automatic show_frame(input logic [27:0] segs);
      for (int k = 0; k < DIGITS; k++) begin
         for (int c = 0; c < SCAN_DIV; c++) begin
            idle();
            check("slot_an", {28'd0, an_o},
                  (c < GUARD) ? 32'hF : {28'd0, ~(4'b0001 << k)});
            check("slot_seg", {25'd0, seg_o},
                  (c < GUARD) ? 32'h0 : {25'd0, segs[7*k +: 7]});
         end
      end
   endtask

   initial begin
      m_pos = 0; m_disp = '0; m_pend = '0; m_dblank = 4'hF; m_pblank = '0; m_pvld = 1'b0;

      // Reset held for three cycles.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 4'h0);
      check("rst_an", {28'd0, an_o}, 32'hF);
      check("rst_seg", {25'd0, seg_o}, 32'h0);
      check("rst_frame", {31'd0, frame_o}, 32'h0);

      // Basic load, displayed from the next frame.
      step(1'b1, 1'b1, 1'b1, 16'h12AF, 4'h0);
      wait_frame();
      show_frame({7'h06, 7'h5B, 7'h77, 7'h71});

      // A mid-frame load takes effect at the next frame. Of two loads in one frame, the last one wins.
      for (int i = 0; i < 5; i++) idle();
      step(1'b1, 1'b1, 1'b1, 16'h1111, 4'h0);
      wait_frame();
      show_frame({7'h06, 7'h06, 7'h06, 7'h06});
      for (int i = 0; i < 3; i++) idle();
      step(1'b1, 1'b1, 1'b1, 16'h2222, 4'h0);
      for (int i = 0; i < 7; i++) idle();
      step(1'b1, 1'b1, 1'b1, 16'h3333, 4'h0);
      wait_frame();
      show_frame({7'h4F, 7'h4F, 7'h4F, 7'h4F});

      // A load on the boundary cycle goes straight to the display.
      seek(FRAME - 1, FRAME);
      step(1'b1, 1'b1, 1'b1, 16'h0BEE, 4'h0);
      check("bypass_frame", {31'd0, frame_o}, 32'd1);
      show_frame({D3_0BEE, 7'h7C, 7'h79, 7'h79});

      // The scan freezes mid-slot, then resumes.
      seek(4, SCAN_DIV);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 1'b0, 16'h0000, 4'h0);
         check("hold_an", {28'd0, an_o}, 32'hF);
      end
      for (int i = 0; i < 2 * FRAME; i++) idle();

      // Randomized traffic: loads, blanking, enable gaps and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         logic r, e, l;
         logic [15:0] v;
         logic [3:0]  b;
         r = ($urandom_range(0, 299) != 0);
         e = ($urandom_range(0, 9) != 0);
         l = ($urandom_range(0, 9) == 0);
         v = 16'($urandom);
         if ($urandom_range(0, 2) == 0) v = v & 16'h00FF;
         if ($urandom_range(0, 7) == 0) v = 16'h0000;
         b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         step(r, e, l, v, b);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
